// File: rtl/d_ff_enable_pkg.sv
// Shared constants and types for the d_ff_enable load-enable register family.
package d_ff_enable_pkg;

   localparam int unsigned DFF_DEFAULT_WIDTH = 1;

   localparam logic [DFF_DEFAULT_WIDTH-1:0] DFF_DEFAULT_RESET_VALUE = '0;

   // Stored value of one single-bit register cell.
   typedef logic dff_bit_state_t;

endpackage : d_ff_enable_pkg

// File: rtl/d_ff_enable_bit.sv
// Single-bit storage cell: synchronous active-high reset with priority over the load enable.
module d_ff_enable_bit
   import d_ff_enable_pkg::*;
#(
   parameter dff_bit_state_t RESET_VALUE = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           d,
   input  logic           enable,
   output dff_bit_state_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VALUE;
      end else if (enable) begin
         q <= d;
      end
   end

endmodule : d_ff_enable_bit

// File: rtl/d_ff_enable.sv
// Parameterised load-enable D register built from d_ff_enable_bit cells.
// Optional change flag output is built when D_FF_ENABLE_CHANGE_FLAG_EN is defined.
module d_ff_enable
   import d_ff_enable_pkg::*;
#(
   parameter int unsigned           WIDTH       = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(DFF_DEFAULT_RESET_VALUE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   input  logic             enable,
   output logic [WIDTH-1:0] Q
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
   ,
   output logic             changed
`endif
);

   // One cell per bit; enable and reset are shared so all bits load together.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      d_ff_enable_bit #(
         .RESET_VALUE (RESET_VALUE[i])
      ) u_bit (
         .clk    (clk),
         .rst    (rst),
         .d      (D[i]),
         .enable (enable),
         .q      (Q[i])
      );
   end

`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
   logic load_differs_c;

   // A load only counts as a change when the captured word differs from the held one.
   always_comb begin
      load_differs_c = 1'b0;
      if (enable) begin
         load_differs_c = |(D ^ Q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         changed <= 1'b0;
      end else begin
         changed <= load_differs_c;
      end
   end
`endif

endmodule : d_ff_enable

// File: tb/tb_d_ff_enable.sv
// Directed self-checking bench for d_ff_enable (1-bit default and 8-bit A5-reset instances).
`timescale 1ns/1ps
module tb_d_ff_enable;

   logic       clk = 1'b0;
   logic       rst1, en1, d1;
   logic       q1;
   logic       rst8, en8;
   logic [7:0] d8, q8;
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
   logic       ch1, ch8;
`endif

   int n_asserts = 0;
   int n_fails   = 0;

   always #5 clk = ~clk;

   d_ff_enable u_dut1 (
      .clk     (clk),
      .rst     (rst1),
      .D       (d1),
      .enable  (en1),
      .Q       (q1)
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
      ,
      .changed (ch1)
`endif
   );

   d_ff_enable #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk     (clk),
      .rst     (rst8),
      .D       (d8),
      .enable  (en8),
      .Q       (q8)
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
      ,
      .changed (ch8)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst1 = 1'b1; en1 = 1'b0; d1 = 1'b0;
      rst8 = 1'b0; en8 = 1'b0; d8 = 8'h00;
      #2;

      // 1: reset then hold while disabled
      step();
      chk("reset_q1", 8'(q1), 8'h00);
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
      chk("reset_ch1", 8'(ch1), 8'h00);
`endif
      rst1 = 1'b0; d1 = 1'b1;
      step();
      chk("hold_d1", 8'(q1), 8'h00);
      d1 = 1'b0;
      step();
      chk("hold_d0", 8'(q1), 8'h00);

      // 2: load when enabled
      en1 = 1'b1; d1 = 1'b1;
      step();
      chk("load_1", 8'(q1), 8'h01);
      d1 = 1'b0;
      step();
      chk("load_0", 8'(q1), 8'h00);

      // 3: enable toggled mid-operation
      en1 = 1'b0; d1 = 1'b1;
      step();
      chk("en_off_q", 8'(q1), 8'h00);
      en1 = 1'b1;
      step();
      chk("en_on_q", 8'(q1), 8'h01);

      // 4: reset beats a simultaneous load, load accepted right after release
      rst1 = 1'b1;
      step();
      chk("rst_prio_q", 8'(q1), 8'h00);
      rst1 = 1'b0;
      step();
      chk("post_rst_load", 8'(q1), 8'h01);

`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
      // 6: change flag pulses once per differing load
      rst1 = 1'b1; en1 = 1'b0;
      step();
      chk("cf_rst_q", 8'(q1), 8'h00);
      chk("cf_rst_ch", 8'(ch1), 8'h00);
      rst1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
      step();
      chk("cf_load_ch", 8'(ch1), 8'h01);
      en1 = 1'b0;
      step();
      chk("cf_pulse_end", 8'(ch1), 8'h00);
      en1 = 1'b1; d1 = 1'b1;
      step();
      chk("cf_same_ch", 8'(ch1), 8'h00);
      chk("cf_same_q", 8'(q1), 8'h01);
      rst1 = 1'b1;
      step();
      chk("cf_rst2_ch", 8'(ch1), 8'h00);
      rst1 = 1'b0; en1 = 1'b0;
`endif

      // 5: wide instance with non-zero reset value
      rst8 = 1'b1; en8 = 1'b1; d8 = 8'h3C;
      step();
      chk("w8_reset", q8, 8'hA5);
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
      chk("w8_reset_ch", 8'(ch8), 8'h00);
`endif
      rst8 = 1'b0;
      step();
      chk("w8_load", q8, 8'h3C);
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
      chk("w8_load_ch", 8'(ch8), 8'h01);
`endif
      en8 = 1'b0; d8 = 8'hFF;
      step();
      chk("w8_hold1", q8, 8'h3C);
`ifdef D_FF_ENABLE_CHANGE_FLAG_EN
      chk("w8_hold_ch", 8'(ch8), 8'h00);
`endif
      step();
      chk("w8_hold2", q8, 8'h3C);
      en8 = 1'b1; d8 = 8'h5A;
      step();
      chk("w8_load2", q8, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule : tb_d_ff_enable
